// File: rtl/trng_word_gen.sv
// Ring-oscillator TRNG with rate divider, von Neumann debiasing, repetition-count
// health test and valid/ready word packing.

module trng #(
  parameter int NUM_OSCILLATORS = 2,
  parameter int NUM_INVERTER    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trng_en,
  output logic trng_out
);

  logic [NUM_OSCILLATORS-1:0] w_taps;
  logic                       r_out;

  // Each oscillator is an odd-length inverting ring advanced once per clock; distinct seeds decorrelate them.
  for (genvar g = 0; g < NUM_OSCILLATORS; g++) begin : g_osc
    logic [NUM_INVERTER-1:0] r_ring;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ring <= NUM_INVERTER'(g);
      end else if (trng_en) begin
        r_ring <= {r_ring[NUM_INVERTER-2:0], ~r_ring[NUM_INVERTER-1]};
      end
    end

    assign w_taps[g] = r_ring[NUM_INVERTER-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 1'b0;
    end else if (trng_en) begin
      r_out <= ^w_taps;
    end
  end

  assign trng_out = r_out;

endmodule

module trng_word_gen #(
  parameter int NUM_OSCILLATORS = 2,
  parameter int NUM_INVERTER    = 3,
  parameter int WORD_WIDTH      = 32,
  parameter int SAMPLE_DIV      = 4,
  parameter int REP_LIMIT       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  debias_en,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  health_fail_o
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int BIT_W = $clog2(WORD_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORD_WIDTH);

  logic                  w_trng_out;
  logic                  r_sync1;
  logic                  r_raw;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [REP_W-1:0]      r_rep_cnt;
  logic [REP_W-1:0]      w_rep_next;
  logic                  r_prev;
  logic                  r_phase;
  logic                  r_first;
  logic                  r_debias_q;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  w_tick;
  logic                  w_fail_now;
  logic                  w_debias_chg;
  logic                  w_emit;
  logic                  w_bit;
  logic                  w_full;
  logic                  w_xfer;

  trng #(
    .NUM_OSCILLATORS(NUM_OSCILLATORS),
    .NUM_INVERTER   (NUM_INVERTER)
  ) trng_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .trng_en (enable),
    .trng_out(w_trng_out)
  );

  // The synchroniser is only reset by rst_n so raw stays valid across enable toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_raw      <= 1'b0;
      r_debias_q <= 1'b0;
    end else begin
      r_sync1    <= w_trng_out;
      r_raw      <= r_sync1;
      r_debias_q <= debias_en;
    end
  end

  assign w_tick       = enable && (r_div_cnt == DIV_MAX);
  assign w_debias_chg = debias_en != r_debias_q;
  assign w_full       = r_bit_cnt == BIT_FULL;

  always_comb begin
    w_rep_next = REP_W'(1);
    if (r_rep_cnt != '0 && r_raw == r_prev) begin
      w_rep_next = (r_rep_cnt == REP_MAX) ? REP_MAX : r_rep_cnt + REP_W'(1);
    end
  end

  assign w_fail_now = w_tick && !health_fail_o && (w_rep_next == REP_MAX);

  // A pair only emits on its second tick, and only when the two samples differ.
  always_comb begin
    w_emit = 1'b0;
    w_bit  = r_raw;
    if (w_tick && !health_fail_o && !w_fail_now) begin
      if (!debias_en) begin
        w_emit = 1'b1;
      end else if (r_phase && !w_debias_chg) begin
        w_emit = r_first != r_raw;
        w_bit  = r_first;
      end
    end
  end

  assign w_xfer = enable && w_full && !w_fail_now && (!valid_o || ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_rep_cnt     <= '0;
      r_prev        <= 1'b0;
      r_phase       <= 1'b0;
      r_first       <= 1'b0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      health_fail_o <= 1'b0;
    end else if (!enable) begin
      r_div_cnt     <= '0;
      r_rep_cnt     <= '0;
      r_phase       <= 1'b0;
      r_bit_cnt     <= '0;
      valid_o       <= 1'b0;
      health_fail_o <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_rep_cnt <= w_rep_next;
        r_prev    <= r_raw;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (w_fail_now || w_debias_chg) begin
        r_phase <= 1'b0;
      end else if (w_tick && debias_en && !health_fail_o) begin
        r_phase <= !r_phase;
        if (!r_phase) begin
          r_first <= r_raw;
        end
      end

      // A bit emitted during a transfer becomes bit 0 of the next word.
      if (w_fail_now) begin
        health_fail_o <= 1'b1;
        valid_o       <= 1'b0;
        r_bit_cnt     <= '0;
      end else if (w_xfer) begin
        data_o    <= r_shreg;
        valid_o   <= 1'b1;
        r_bit_cnt <= w_emit ? BIT_W'(1) : '0;
      end else begin
        if (valid_o && ready_i) begin
          valid_o <= 1'b0;
        end
        if (w_emit && !w_full) begin
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
      end

      if (w_emit && (!w_full || w_xfer)) begin
        r_shreg <= {r_shreg[WORD_WIDTH-2:0], w_bit};
      end
    end
  end

endmodule

// File: tb/tb_trng_word_gen.sv
// Scoreboard bench for trng_word_gen: forces the core output and checks packed words,
// backpressure, health failure, async reset and the sample divider.

module tb_trng_word_gen;

  logic       clk = 1'b0;
  logic       rstN;
  logic       enable1, debias1, ready1;
  logic [7:0] data1;
  logic       valid1, health1;
  logic       enable2, debias2, ready2;
  logic [7:0] data2;
  logic       valid2, health2;
  logic       rawDrive1, rawDrive2;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] expQ1[$];
  logic [7:0] expQ2[$];
  logic [39:0] divPat = 40'h9D_6B2C_35E1;

  always #5 clk = ~clk;

  trng_word_gen #(
    .NUM_OSCILLATORS(2), .NUM_INVERTER(3), .WORD_WIDTH(8), .SAMPLE_DIV(1), .REP_LIMIT(16)
  ) u_dut (
    .clk(clk), .rst_n(rstN), .enable(enable1), .debias_en(debias1), .ready_i(ready1),
    .data_o(data1), .valid_o(valid1), .health_fail_o(health1)
  );

  trng_word_gen #(
    .NUM_OSCILLATORS(2), .NUM_INVERTER(3), .WORD_WIDTH(8), .SAMPLE_DIV(4), .REP_LIMIT(16)
  ) u_dutDiv4 (
    .clk(clk), .rst_n(rstN), .enable(enable2), .debias_en(debias2), .ready_i(ready2),
    .data_o(data2), .valid_o(valid2), .health_fail_o(health2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Feeds samples MSB-first; enable rises so the first tick sees bits[n-1] through the 2-flop synchroniser.
  task automatic applyStimulus(input logic [63:0] bits, input int n);
    for (int i = 0; i <= n + 1; i++) begin
      @(negedge clk);
      rawDrive1 = (i < n) ? bits[n-1-i] : 1'b0;
      enable1   = (i >= 2);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #1;
    if (rstN && valid1 && ready1) begin
      if (expQ1.size() == 0) checkOutput("spuriousWord1", 32'(valid1), 32'd0);
      else checkOutput("word1", 32'(data1), 32'(expQ1.pop_front()));
    end
  end

  always @(negedge clk) begin
    #1;
    if (rstN && valid2 && ready2) begin
      if (expQ2.size() == 0) checkOutput("spuriousWord2", 32'(valid2), 32'd0);
      else checkOutput("word2", 32'(data2), 32'(expQ2.pop_front()));
    end
  end

  initial begin
    logic [7:0] exp2;
    force u_dut.trng_i.trng_out     = rawDrive1;
    force u_dutDiv4.trng_i.trng_out = rawDrive2;
    rstN = 1'b0; rawDrive1 = 1'b0; rawDrive2 = 1'b0;
    enable1 = 1'b0; debias1 = 1'b0; ready1 = 1'b1;
    enable2 = 1'b0; debias2 = 1'b0; ready2 = 1'b1;
    waitCycles(3);
    #1;
    checkOutput("resetData1", 32'(data1), 32'd0);
    checkOutput("resetValid1", 32'(valid1), 32'd0);
    checkOutput("resetHealth1", 32'(health1), 32'd0);
    checkOutput("resetData2", 32'(data2), 32'd0);
    checkOutput("resetValid2", 32'(valid2), 32'd0);
    checkOutput("resetHealth2", 32'(health2), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    waitCycles(2);

    $display("[TB] raw mode word");
    expQ1.push_back(8'hB2);
    applyStimulus(64'hB2, 8);
    waitCycles(5);
    #1;
    checkOutput("rawValidAfter", 32'(valid1), 32'd0);
    checkOutput("rawHealth", 32'(health1), 32'd0);
    enable1 = 1'b0;
    waitCycles(2);

    $display("[TB] debias mode word");
    debias1 = 1'b1;
    waitCycles(2);
    expQ1.push_back(8'h6D);
    applyStimulus(64'h68DA6, 20);
    waitCycles(5);
    #1;
    checkOutput("debiasHealth", 32'(health1), 32'd0);
    enable1 = 1'b0;
    debias1 = 1'b0;
    waitCycles(3);

    $display("[TB] backpressure");
    ready1 = 1'b0;
    expQ1.push_back(8'hA5);
    expQ1.push_back(8'h3C);
    applyStimulus(64'hA53C96, 24);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput("bpValidHeld", 32'(valid1), 32'd1);
      checkOutput("bpDataHeld", 32'(data1), 32'hA5);
    end
    @(negedge clk);
    ready1 = 1'b1;
    waitCycles(4);
    enable1 = 1'b0;
    waitCycles(2);

    $display("[TB] health failure");
    expQ1.push_back(8'hFF);
    applyStimulus(64'hFFFF, 16);
    #1;
    checkOutput("healthBeforeTrip", 32'(health1), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("healthTripped", 32'(health1), 32'd1);
    checkOutput("healthValid", 32'(valid1), 32'd0);
    waitCycles(20);
    #1;
    checkOutput("healthSticky", 32'(health1), 32'd1);
    @(negedge clk);
    enable1 = 1'b0;
    @(negedge clk);
    enable1 = 1'b1;
    #1;
    checkOutput("healthCleared", 32'(health1), 32'd0);
    waitCycles(3);
    #1;
    checkOutput("healthStaysClear", 32'(health1), 32'd0);
    enable1 = 1'b0;
    waitCycles(2);

    $display("[TB] async reset mid-word");
    ready1 = 1'b0;
    applyStimulus(64'hC3, 8);
    waitCycles(3);
    #1;
    checkOutput("preResetValid", 32'(valid1), 32'd1);
    checkOutput("preResetData", 32'(data1), 32'hC3);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("asyncData", 32'(data1), 32'd0);
    checkOutput("asyncValid", 32'(valid1), 32'd0);
    checkOutput("asyncHealth", 32'(health1), 32'd0);
    enable1 = 1'b0;
    ready1  = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    waitCycles(2);
    expQ1.push_back(8'h4E);
    applyStimulus(64'h4E, 8);
    waitCycles(5);
    enable1 = 1'b0;
    waitCycles(2);

    $display("[TB] sample divider of 4");
    exp2 = '0;
    for (int j = 0; j < 8; j++) exp2[7-j] = divPat[4*j+3];
    expQ2.push_back(exp2);
    for (int c = -2; c <= 33; c++) begin
      @(negedge clk);
      rawDrive2 = divPat[c+2];
      enable2   = (c >= 0);
      if (c == 32) begin #1; checkOutput("div4NotYet", 32'(valid2), 32'd0); end
      if (c == 33) begin #1; checkOutput("div4Valid", 32'(valid2), 32'd1); end
    end
    waitCycles(2);
    enable2 = 1'b0;
    waitCycles(2);

    checkOutput("pendingWords1", 32'(expQ1.size()), 32'd0);
    checkOutput("pendingWords2", 32'(expQ2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trng_word_gen.md
# trng_word_gen

Parametrised successor to the fixed-size TRNG wrappers. It instantiates the `trng` ring-oscillator core with configurable oscillator and inverter counts. It samples the raw bit at a programmable rate, optionally debiases it with a von Neumann corrector, and runs a repetition-count health test. Accepted bits are packed into `WORD_WIDTH`-bit words and delivered over a valid/ready interface to the SoC peripheral bus logic.

## Interface
- `NUM_OSCILLATORS`, 2: ring oscillators in `trng` core (≥1)
- `NUM_INVERTER`, 3: inverters per oscillator (odd, ≥3)
- `WORD_WIDTH`, 32: output word width (≥2)
- `SAMPLE_DIV`, 4: raw sample taken every `SAMPLE_DIV` clocks (≥1)
- `REP_LIMIT`, 16: consecutive identical raw samples that trip the health test (≥2)

Ports:
- `clk`  in  1: system clock, also the `trng` sampling clock
- `rst_n`  in  1: asynchronous active-low reset
- `enable`  in  1: drives `trng_en`; low clears all state except `data_o`
- `debias_en`  in  1: 1 = von Neumann debiasing, 0 = raw samples used directly
- `ready_i`  in  1: consumer accepts word when `valid_o & ready_i`
- `data_o`  out  `WORD_WIDTH`: output word, stable while `valid_o`
- `valid_o`  out  1: word available
- `health_fail_o`  out  1: sticky repetition-count failure

## Operation
- Core instance `trng_i` (`trng`, params passed through) has `trng_en = enable`. `trng_out` passes through a 2-flop synchroniser to give `raw`.
- Divider counter `div_cnt` counts 0..`SAMPLE_DIV`-1 while `enable`. A sample tick is generated when `div_cnt == SAMPLE_DIV-1`, and the counter then wraps to 0. With `SAMPLE_DIV=1`, every cycle is a tick.
- Health test, on every tick:
  - If `raw` equals the previous sample, `rep_cnt` increments, saturating at `REP_LIMIT`. Otherwise `rep_cnt` is set to 1.
  - The first tick after enable sets `rep_cnt` to 1.
  - When `rep_cnt` reaches `REP_LIMIT`, `health_fail_o` is set.
- Debias (`debias_en=1`): ticks are grouped in pairs (first/second).
  - Pair 01 emits bit 0; pair 10 emits bit 1; pairs 00 and 11 emit nothing.
  - The pair phase resets on enable, on a failure, and on a change of `debias_en`.
- Raw mode (`debias_en=0`): every tick emits `raw`.
- Emitted bits go into the shift register as `shreg <= {shreg[W-2:0], bit}`, and `bit_cnt` increments.
  - When `bit_cnt == WORD_WIDTH`, the shift register is full and further emitted bits are dropped.
- Transfer to output happens in any cycle where the shift register is full and (`!valid_o` or `ready_i`):
  - `data_o <= shreg`, `valid_o <= 1`, `bit_cnt <= 0`.
  - A bit emitted in the same cycle is stored as bit 0 of the new word (`bit_cnt <= 1`).
- `valid_o & ready_i` with no transfer clears `valid_o`.
- On failure (the cycle `health_fail_o` rises):
  - `valid_o` is cleared, and `bit_cnt` and the pair phase are cleared.
  - While `health_fail_o=1`, no bits are emitted and no words are produced.
- `enable=0`: clears `div_cnt`, `rep_cnt`, `bit_cnt`, the pair phase, `valid_o` and `health_fail_o`. `data_o` holds its value. Clearing the failure requires dropping `enable`.
- A word in flight (`valid_o=1`) when `enable` falls is discarded.

## Timing
- Reset values: `data_o=0`, `valid_o=0`, `health_fail_o=0`; all counters and synchroniser flops are 0.
- `trng_out` to `raw`: 2 cycles.
- Tick to emitted bit landing in `shreg`: 1 cycle.
- Full shift register to `valid_o`: 1 cycle. There is no bubble between consecutive words when `ready_i` is held high.
- `health_fail_o` rises 1 cycle after the tick that brings `rep_cnt` to `REP_LIMIT`.
- Raw mode throughput: 1 word per `WORD_WIDTH*SAMPLE_DIV` cycles.
- `valid_o` never deasserts without a handshake, except on failure or `enable=0`.
- `data_o` never changes while `valid_o=1 & !ready_i`.
- Deasserting `rst_n` asynchronously forces all reset values, including mid-word.

## Test plan
Bench forces `trng_i.trng_out` for deterministic stimulus.
- Raw mode, `WORD_WIDTH=8`, `SAMPLE_DIV=1`, `REP_LIMIT=16`, forced pattern 1,0,1,1,0,0,1,0, `ready_i=1` -> `valid_o` pulses once with `data_o=8'hB2`, and `health_fail_o` stays 0.
- Debias mode, pairs 01,10,10,00,11,01,10,10,01,10 -> emitted bits 0,1,1,0,1,1,0,1 give `data_o=8'h6D`; the 00 and 11 pairs add no bits.
- Backpressure: `ready_i=0` for 3 words' worth of ticks -> `data_o` holds the first word. The second word waits in `shreg` and later bits are dropped. When `ready_i` rises, the second word appears on the next cycle.
- Health: constant 1 for 16 ticks -> `health_fail_o=1` one cycle after the 16th tick, `valid_o=0`, and no further words. Pulsing `enable` low for 1 cycle clears the failure.
- `SAMPLE_DIV=4`: toggling input -> bits are captured only on every 4th cycle, and an 8-bit word takes 32 cycles.
- Async reset asserted mid-word with `valid_o=1` -> all outputs return to 0 immediately. After release, the next word starts from an empty register.
